// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding and
// default bus widths.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FULL = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

  localparam int ADDR_W_DEF      = 16;
  localparam int DATA_W_DEF      = 16;
  localparam int ACK_TIMEOUT_DEF = 15;

endpackage

// File: rtl/instruction_fetch_timeout_counter.sv
// Saturating wait-cycle counter for an outstanding memory read; flags
// expiry once the count reaches LIMIT.
module fetch_timeout_counter #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

  logic [CNT_W-1:0] count_q, count_d;

  // Saturates at LIMIT so a long stall cannot wrap back below the threshold
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LIMIT_V)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LIMIT_V);

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: samples the PC, issues a memory read, latches the
// returned word into IR and hands it to the decoder with valid/ready.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] PC_Q,
  output logic              PC_EN,
  output logic              PC_INC,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_REQ,
  input  logic              MEM_ACK,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              STALL,
  input  logic              FLUSH,
  output logic [DATA_W-1:0] IR,
  output logic              IR_VALID,
  input  logic              IR_READY,
  output logic              FAULT
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              mem_req_q, mem_req_d;
  logic              ir_valid_q, ir_valid_d;
  logic              pc_inc_q, pc_inc_d;
  logic              fault_q, fault_d;
  logic              drop_q, drop_d;
  logic              pc_en;
  logic              expired;

  assign pc_en = (state_q == ST_IDLE) && !STALL && !FLUSH && !fault_q;

  fetch_timeout_counter #(
    .LIMIT(ACK_TIMEOUT)
  ) u_timeout (
    .clk    (CLK),
    .rst_n  (RST),
    .clear  (state_q != ST_WAIT),
    .enable ((state_q == ST_WAIT) && !MEM_ACK),
    .expired(expired)
  );

  // A flushed fetch still completes on the bus; only its data is thrown away
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = mem_req_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    pc_inc_d   = 1'b0;
    fault_d    = fault_q;
    drop_d     = drop_q;
    case (state_q)
      ST_IDLE: begin
        if (FLUSH) ir_valid_d = 1'b0;
        if (pc_en) begin
          mem_addr_d = PC_Q;
          mem_req_d  = 1'b1;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (MEM_ACK) begin
          mem_req_d = 1'b0;
          if (drop_q || FLUSH) begin
            drop_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            ir_d       = MEM_RDATA;
            ir_valid_d = 1'b1;
            pc_inc_d   = 1'b1;
            state_d    = ST_FULL;
          end
        end else if (expired) begin
          mem_req_d = 1'b0;
          fault_d   = 1'b1;
          state_d   = ST_HALT;
        end else if (FLUSH) begin
          drop_d = 1'b1;
        end
      end
      ST_FULL: begin
        if (FLUSH || IR_READY) begin
          ir_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      ST_HALT: begin
        mem_req_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      pc_inc_q   <= 1'b0;
      fault_q    <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      pc_inc_q   <= pc_inc_d;
      fault_q    <= fault_d;
      drop_q     <= drop_d;
    end
  end

  assign PC_EN    = pc_en;
  assign PC_INC   = pc_inc_q;
  assign MEM_ADDR = mem_addr_q;
  assign MEM_REQ  = mem_req_q;
  assign IR       = ir_q;
  assign IR_VALID = ir_valid_q;
  assign FAULT    = fault_q;

endmodule
